// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR stage driving a 1-cycle registered ROM, with jump targets and halt on illegal address.
// Define IFU_HALT_ON_NOP_EN to also halt when the latched opcode equals HALT_OPCODE.
module instr_fetch_unit #(
   parameter int          PC_W        = 8,
   parameter int          PROG_LEN    = 164,
   parameter logic [5:0]  HALT_OPCODE = 6'd46
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_req,
   input  logic            jump_en,
   input  logic [PC_W-1:0] jump_target,
   input  logic [15:0]     rom_data,
   output logic [PC_W-1:0] rom_addr,
   output logic [5:0]      opcode,
   output logic [9:0]      operand,
   output logic [PC_W-1:0] pc,
   output logic            ir_valid,
   output logic            busy,
   output logic            halted,
   output logic            addr_err
);
`ifdef IFU_HALT_ON_NOP_EN
   localparam bit HALT_ON_NOP = 1'b1;
`else
   localparam bit HALT_ON_NOP = 1'b0;
`endif
   localparam logic [PC_W:0] LEN = (PC_W+1)'(PROG_LEN);
   typedef enum logic [1:0] {IDLE, WAIT, LATCH, HALT} state_t;
   state_t          state, state_nx;
   logic [15:0]     ir, ir_nx;
   logic [PC_W-1:0] pc_nx, rom_addr_nx, fa;
   logic            ir_valid_nx, addr_err_nx, illegal, halt_hit;
   assign fa       = jump_en ? jump_target : pc;
   assign illegal  = {1'b0, fa} >= LEN;
   assign halt_hit = HALT_ON_NOP && (rom_data[15:10] == HALT_OPCODE);
   assign opcode   = ir[15:10];
   assign operand  = ir[9:0];
   assign busy     = (state == WAIT) || (state == LATCH);
   assign halted   = state == HALT;
   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      rom_addr_nx = rom_addr;
      ir_nx       = ir;
      ir_valid_nx = ir_valid;
      addr_err_nx = addr_err;
      case (state)
         IDLE: if (fetch_req) begin
            ir_valid_nx = 1'b0;
            addr_err_nx = illegal;
            rom_addr_nx = illegal ? rom_addr : fa;
            state_nx    = illegal ? HALT : WAIT;
         end
         WAIT: state_nx = LATCH;
         // rom_addr still names the word now on rom_data, so it is the PC source
         LATCH: begin
            ir_nx       = rom_data;
            pc_nx       = rom_addr + 1'b1;
            ir_valid_nx = 1'b1;
            state_nx    = halt_hit ? HALT : IDLE;
         end
         HALT: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= '0;
         rom_addr <= '0;
         ir       <= '0;
         ir_valid <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         rom_addr <= rom_addr_nx;
         ir       <= ir_nx;
         ir_valid <= ir_valid_nx;
         addr_err <= addr_err_nx;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a registered ROM model and an expected-instruction queue.
module tb_instr_fetch_unit;
`ifdef IFU_HALT_ON_NOP_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif
   typedef struct packed {logic [5:0] op; logic [9:0] opd; logic [7:0] pc;} exp_t;
   logic        clk = 1'b0, rst_n = 1'b0, fetch_req = 1'b0, jump_en = 1'b0;
   logic [7:0]  jump_target = '0;
   logic [15:0] rom_data;
   logic [7:0]  rom_addr, pc;
   logic [5:0]  opcode;
   logic [9:0]  operand;
   logic        ir_valid, busy, halted, addr_err;
   logic [15:0] rom [0:255];
   exp_t        sb [$];
   logic [7:0]  mpc = '0, m_addr = '0;
   int          n_cmp = 0, n_bad = 0;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .jump_en(jump_en),
      .jump_target(jump_target), .rom_data(rom_data), .rom_addr(rom_addr),
      .opcode(opcode), .operand(operand), .pc(pc), .ir_valid(ir_valid),
      .busy(busy), .halted(halted), .addr_err(addr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pc"}, pc, 0);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_opcode"}, opcode, 0);
      chk({tag, "_operand"}, operand, 0);
      chk({tag, "_ir_valid"}, ir_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_addr_err"}, addr_err, 0);
   endtask

   task automatic fetch(input logic j, input logic [7:0] t, input logic pulse);
      logic [7:0] fa;
      exp_t e;
      int lat;
      fa = j ? t : mpc;
      e.op = rom[fa][15:10];
      e.opd = rom[fa][9:0];
      e.pc = fa + 8'd1;
      sb.push_back(e);
      fetch_req = 1'b1; jump_en = j; jump_target = t;
      @(negedge clk);
      fetch_req = pulse; jump_en = pulse; jump_target = 8'd5;
      chk("rom_addr", rom_addr, fa);
      chk("busy", busy, 1);
      chk("ir_valid_low", ir_valid, 0);
      lat = 0;
      while (!ir_valid && lat < 6) begin
         @(negedge clk);
         lat++;
         if (lat >= 2) begin fetch_req = 1'b0; jump_en = 1'b0; end
      end
      fetch_req = 1'b0; jump_en = 1'b0;
      chk("latency", lat, 2);
      chk("rom_addr_hold", rom_addr, fa);
      chk("sb_depth", sb.size(), 1);
      e = sb.pop_front();
      chk("opcode", opcode, e.op);
      chk("operand", operand, e.opd);
      chk("pc", pc, e.pc);
      chk("busy_done", busy, 0);
      chk("halted", halted, HALT_EN && e.op == 6'd46);
      mpc = fa + 8'd1;
      m_addr = fa;
   endtask

   task automatic bad_fetch(input logic j, input logic [7:0] t);
      fetch_req = 1'b1; jump_en = j; jump_target = t;
      @(negedge clk);
      chk("err_addr_err", addr_err, 1);
      chk("err_halted", halted, 1);
      chk("err_ir_valid", ir_valid, 0);
      chk("err_busy", busy, 0);
      chk("err_rom_addr", rom_addr, m_addr);
      repeat (3) @(negedge clk);
      fetch_req = 1'b0; jump_en = 1'b0;
      chk("err_stay_halted", halted, 1);
      chk("err_stay_rom_addr", rom_addr, m_addr);
   endtask

   task automatic restart();
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      mpc = '0; m_addr = '0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = {6'(i % 40), 10'(i * 37 + 5)};
      rom[0]   = {6'd2, 10'd0};
      rom[63]  = {6'd25, 10'd0};
      rom[159] = {6'd19, 10'd869};
      rom[163] = {6'd46, 10'd0};
      #1 chk_zero("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fetch(1'b0, 8'd0, 1'b0);
      chk("first_opcode", opcode, 2);
      fetch(1'b0, 8'd0, 1'b1);
      fetch(1'b0, 8'd0, 1'b0);
      fetch(1'b0, 8'd0, 1'b1);
      chk("four_pc", pc, 4);
      chk("four_rom_addr", rom_addr, 3);
      fetch(1'b1, 8'd142, 1'b0);
      chk("pc_143", pc, 143);
      fetch(1'b1, 8'd63, 1'b0);
      chk("jump63_opcode", opcode, 25);
      fetch(1'b1, 8'd159, 1'b0);
      chk("jump159_operand", operand, 869);
      fetch(1'b1, 8'd163, 1'b0);
      chk("nop_opcode", opcode, 46);
      chk("nop_pc", pc, 164);
      if (HALT_EN) begin
         fetch_req = 1'b1;
         repeat (3) @(negedge clk);
         fetch_req = 1'b0;
         chk("nop_halt_rom_addr", rom_addr, 163);
         chk("nop_halt_pc", pc, 164);
         chk("nop_halt_valid", ir_valid, 1);
         chk("nop_halt_halted", halted, 1);
      end else begin
         bad_fetch(1'b0, 8'd0);
         chk("wrap_ir_held", opcode, 46);
      end
      restart();
      bad_fetch(1'b1, 8'd200);
      restart();
      fetch_req = 1'b1; jump_en = 1'b1; jump_target = 8'd10;
      @(negedge clk);
      fetch_req = 1'b0; jump_en = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_rom_addr", rom_addr, 10);
      #2 rst_n = 1'b0;
      #1 chk_zero("async");
      @(negedge clk);
      rst_n = 1'b1;
      mpc = '0; m_addr = '0;
      fetch(1'b0, 8'd0, 1'b0);
      chk("after_rst_opcode", opcode, 2);
      chk("after_rst_pc", pc, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
